// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_M0   = 2'd1;
  localparam logic [1:0] OWNER_M1   = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_burst_counter.sv
// Saturating tenure counter; limit flags the transfer that
// reaches MAX_BURST.
module burst_counter #(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic limit
);

  localparam int W = $clog2(MAX_BURST + 1);
  localparam logic [W-1:0] MAXV = W'(MAX_BURST);
  localparam logic [W-1:0] LIMV = W'(MAX_BURST - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAXV)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign limit = inc && (cnt_q >= LIMV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter with burst limit and round-robin ties.
// ARB_FIXED_PRIORITY_EN: master 0 wins every tie instead.
import mem_bus_pkg::*;

module mem_bus_arbiter #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [1:0]        owner
);

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   rv0_q, rv0_d;
  logic   rv1_q, rv1_d;
  logic   xfer0, xfer1;
  logic   limit;
  state_e tie;

  assign m0_gnt = (state_q == OWN0);
  assign m1_gnt = (state_q == OWN1);
  assign xfer0  = m0_req && m0_gnt;
  assign xfer1  = m1_req && m1_gnt;

  // last_q: 0 = M0 served last, 1 = M1 served last
`ifdef ARB_FIXED_PRIORITY_EN
  assign tie = OWN0;
`else
  assign tie = last_q ? OWN0 : OWN1;
`endif

  burst_counter #(
    .MAX_BURST(MAX_BURST)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst),
    .clr  (state_d != state_q),
    .inc  (xfer0 || xfer1),
    .limit(limit)
  );

  always_comb begin
    mem_address  = '0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    unique case (1'b1)
      xfer0: begin
        mem_address  = m0_addr;
        mem_data_in  = m0_wdata;
        mem_write_en = m0_we;
      end
      xfer1: begin
        mem_address  = m1_addr;
        mem_data_in  = m1_wdata;
        mem_write_en = m1_we;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = tie;
        else if (m0_req)      state_d = OWN0;
        else if (m1_req)      state_d = OWN1;
      end
      OWN0: begin
        if (!m0_req)               state_d = m1_req ? OWN1 : IDLE;
        else if (m1_req && limit)  state_d = OWN1;
      end
      OWN1: begin
        if (!m1_req)               state_d = m0_req ? OWN0 : IDLE;
        else if (m0_req && limit)  state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      if (state_d == OWN0) last_d = 1'b0;
      if (state_d == OWN1) last_d = 1'b1;
    end
  end

  assign rv0_d = xfer0 && !m0_we;
  assign rv1_d = xfer1 && !m1_we;

  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rv0_q ? mem_data_out : '0;
  assign m1_rdata  = rv1_q ? mem_data_out : '0;

  always_comb begin
    owner = OWNER_NONE;
    unique case (state_q)
      OWN0:    owner = OWNER_M0;
      OWN1:    owner = OWNER_M1;
      default: owner = OWNER_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: rule-level model, per-cycle compare,
// plus directed literal checks.
module tb_mem_bus_arbiter;

  localparam int MAXB = 4;
`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [7:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write_en;
  logic [7:0] m0_rdata, m1_rdata, mem_address, mem_data_in;
  logic [7:0] mem_data_out = 8'h00;
  logic [1:0] owner;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // model state: owner 0 none / 1 M0 / 2 M1
  int         e_own = 0;
  int         e_cnt = 0;
  int         e_last = 2;
  bit         e_rv0 = 0, e_rv1 = 0;
  logic [7:0] e_rd0 = 0, e_rd1 = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .m1_rvalid(m1_rvalid),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
    .owner(owner)
  );

  // synchronous memory device
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nxt_own(int own, int cnt, int last, bit r0, bit r1);
    if (own == 0) begin
      if (r0 && r1) return FIXED ? 1 : ((last == 2) ? 1 : 2);
      if (r0) return 1;
      if (r1) return 2;
      return 0;
    end
    if (own == 1) begin
      if (!r0) return r1 ? 2 : 0;
      if (r1 && (cnt + 1 >= MAXB)) return 2;
      return 1;
    end
    if (!r1) return r0 ? 1 : 0;
    if (r0 && (cnt + 1 >= MAXB)) return 1;
    return 2;
  endfunction

  function automatic int nxt_cnt(int own, int cnt, int last, bit r0, bit r1);
    int n;
    int c;
    n = nxt_own(own, cnt, last, r0, r1);
    if (n != own) return 0;
    c = cnt + (((own == 1 && r0) || (own == 2 && r1)) ? 1 : 0);
    return (c > MAXB) ? MAXB : c;
  endfunction

  function automatic int nxt_last(int own, int cnt, int last, bit r0, bit r1);
    int n;
    n = nxt_own(own, cnt, last, r0, r1);
    if (n != own && n != 0) return n;
    return last;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_own  <= 0;
      e_cnt  <= 0;
      e_last <= 2;
      e_rv0  <= 0;
      e_rv1  <= 0;
      e_rd0  <= 0;
      e_rd1  <= 0;
    end else begin
      e_own  <= nxt_own(e_own, e_cnt, e_last, m0_req, m1_req);
      e_cnt  <= nxt_cnt(e_own, e_cnt, e_last, m0_req, m1_req);
      e_last <= nxt_last(e_own, e_cnt, e_last, m0_req, m1_req);
      e_rv0  <= (e_own == 1) && m0_req && !m0_we;
      e_rv1  <= (e_own == 2) && m1_req && !m1_we;
      e_rd0  <= mem[m0_addr];
      e_rd1  <= mem[m1_addr];
    end
  end

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      chk("m0_gnt", m0_gnt, e_own == 1);
      chk("m1_gnt", m1_gnt, e_own == 2);
      chk("owner", owner, e_own);
      chk("mem_we", mem_write_en,
          (e_own == 1 && m0_req && m0_we) || (e_own == 2 && m1_req && m1_we));
      chk("mem_addr", mem_address,
          (e_own == 1 && m0_req) ? m0_addr :
          (e_own == 2 && m1_req) ? m1_addr : 0);
      chk("mem_din", mem_data_in,
          (e_own == 1 && m0_req) ? m0_wdata :
          (e_own == 2 && m1_req) ? m1_wdata : 0);
      chk("m0_rvalid", m0_rvalid, e_rv0);
      chk("m1_rvalid", m1_rvalid, e_rv1);
      chk("m0_rdata", m0_rdata, e_rv0 ? e_rd0 : 0);
      chk("m1_rdata", m1_rdata, e_rv1 ? e_rd1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r0, input logic w0,
                     input logic [7:0] a0, input logic [7:0] d0,
                     input logic r1, input logic w1,
                     input logic [7:0] a1, input logic [7:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  initial begin
    int n0;
    int gap;
    int got1;
    int run;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hC3;
    mem[8'h30] = 8'h96;

    #2;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_we", mem_write_en, 0);
    chk("rst_mem_addr", mem_address, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    cmp_en = 1'b1;

    // single master write
    step();
    drv(1, 1, 8'h20, 8'h5A, 0, 0, 0, 0);
    @(negedge clk);
    chk("lat_cycle0_gnt", m0_gnt, 0);
    @(negedge clk);
    chk("wr_m0_gnt", m0_gnt, 1);
    chk("wr_mem_we", mem_write_en, 1);
    chk("wr_mem_addr", mem_address, 8'h20);
    chk("wr_mem_din", mem_data_in, 8'h5A);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();

    // master 1 read return
    drv(0, 0, 0, 0, 1, 0, 8'h10, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rd_m1_gnt", m1_gnt, 1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd_m1_rvalid", m1_rvalid, 1);
    chk("rd_m1_rdata", m1_rdata, 8'hC3);
    chk("rd_m0_rvalid", m0_rvalid, 0);
    repeat (2) step();

    // burst limit with m1 waiting; m0 reads 0x30
    drv(1, 0, 8'h30, 0, 1, 1, 8'h40, 8'h77);
    @(negedge clk);
    n0 = 0; gap = 0; got1 = 0;
    for (int i = 0; i < 20 && got1 == 0; i++) begin
      @(negedge clk);
      if (m1_gnt) begin
        got1 = 1;
        chk("burst_m0_rvalid", m0_rvalid, 1);
        chk("burst_m0_rdata", m0_rdata, 8'h96);
      end else if (m0_gnt) n0++;
      else gap++;
    end
    chk("burst_handover", got1, 1);
    chk("burst_m0_xfers", n0, MAXB);
    chk("burst_gap", gap, 0);

    // m1 leaves; m0 keeps the bus for a long tenure
    step();
    drv(1, 0, 8'h30, 0, 0, 0, 0, 0);
    @(negedge clk);
    run = 0;
    repeat (12) begin
      @(negedge clk);
      if (m0_gnt && m0_req) run++;
    end
    chk("long_tenure", run, 12);

    // reset mid-burst
    #2 rst = 1'b0;
    #1;
    chk("midrst_m0_gnt", m0_gnt, 0);
    chk("midrst_m1_gnt", m1_gnt, 0);
    chk("midrst_m0_rvalid", m0_rvalid, 0);
    chk("midrst_m1_rvalid", m1_rvalid, 0);
    chk("midrst_mem_we", mem_write_en, 0);
    chk("midrst_owner", owner, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;

    // tie after reset, then round robin
    step();
    drv(1, 1, 8'h50, 8'h11, 1, 1, 8'h51, 8'h22);
    @(negedge clk);
    @(negedge clk);
    chk("tie1_m0_gnt", m0_gnt, 1);
    chk("tie1_m1_gnt", m1_gnt, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    drv(1, 1, 8'h50, 8'h11, 1, 1, 8'h51, 8'h22);
    @(negedge clk);
    @(negedge clk);
    chk("tie2_m1_gnt", m1_gnt, FIXED ? 0 : 1);
    chk("tie2_m0_gnt", m0_gnt, FIXED ? 1 : 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();

    // handover on release
    drv(1, 0, 8'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("ho_m0_gnt", m0_gnt, 1);
    step();
    drv(1, 0, 8'h10, 0, 1, 1, 8'h60, 8'h33);
    @(negedge clk);
    step();
    drv(0, 0, 8'h10, 0, 1, 1, 8'h60, 8'h33);
    @(negedge clk);
    chk("ho_m0_rvalid", m0_rvalid, 1);
    chk("ho_m0_rdata", m0_rdata, 8'hC3);
    @(negedge clk);
    chk("ho_m1_gnt", m1_gnt, 1);
    chk("ho_owner", owner, 2);
    chk("ho_mem_we", mem_write_en, 1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
